// File: rtl/text_console_writer.sv
// text_console_writer
//
// Write side of the VGA text-mode console. Consumes a stream of character
// codes, keeps a cursor, and turns each code into at most one cell write on
// the screen RAM write port. Row advances clear the new row. Reset and form
// feed clear the whole screen. The display path reads the screen RAM on its
// own port.
//
// Optional feature macro: TEXT_CONSOLE_TAB_EN
//   defined   : 0x09 moves the cursor to the next multiple of TAB_W
//               (a row advance if that passes the last column)
//   undefined : 0x09 is ignored like other control codes
//
// Ports
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous active-high reset; starts a full-screen clear
//   in_valid  in   in_char holds a code to consume
//   in_ready  out  code is taken when in_valid && in_ready at a rising edge
//   in_char   in   character or control code
//   wr_en     out  screen RAM write strobe, one cycle per cell
//   wr_x      out  write column
//   wr_y      out  write row
//   wr_char   out  code written
//   cursor_x  out  current cursor column
//   cursor_y  out  current cursor row
//   busy      out  high whenever a clear is in progress (or in reset)

module text_console_writer #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         TAB_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  output logic       wr_en,
  output logic [7:0] wr_x,
  output logic [6:0] wr_y,
  output logic [7:0] wr_char,
  output logic [7:0] cursor_x,
  output logic [6:0] cursor_y,
  output logic       busy
);

  // Reject geometries the 8-bit column and 7-bit row ports cannot address.
  if (COLS < 2 || COLS > 256 || ROWS < 2 || ROWS > 128 || TAB_W < 1) begin : g_param_check
    $error("text_console_writer: parameter out of range");
  end

  localparam logic [7:0] X_MAX = 8'(COLS - 1);
  localparam logic [6:0] Y_MAX = 7'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
`ifdef TEXT_CONSOLE_TAB_EN
  localparam logic [7:0] CH_HT = 8'h09;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    CLRROW
  } state_t;

  state_t     state;
  logic [7:0] fill_x;
  logic [6:0] fill_y;

  logic       is_print;
  logic [6:0] next_row;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = !in_ready;

  always_comb begin
    is_print = (in_char >= 8'h20) && (in_char != 8'h7F);
    next_row = (cursor_y == Y_MAX) ? '0 : cursor_y + 7'd1;
  end

`ifdef TEXT_CONSOLE_TAB_EN
  // Next tab stop, kept wide so stops past the last column are detectable.
  logic [15:0] tab_next;
  logic        tab_wrap;

  always_comb begin
    tab_next = ((16'(cursor_x) / 16'(TAB_W)) + 16'd1) * 16'(TAB_W);
    tab_wrap = tab_next >= 16'(COLS);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      fill_x   <= '0;
      fill_y   <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
      wr_en    <= 1'b0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_char  <= FILL_CHAR;
    end else begin
      // Strobe is single-cycle; address/data hold their last value.
      wr_en <= 1'b0;

      case (state)
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_x    <= fill_x;
          wr_y    <= fill_y;
          wr_char <= FILL_CHAR;
          if (fill_x == X_MAX) begin
            fill_x <= '0;
            if (fill_y == Y_MAX) begin
              fill_y <= '0;
              state  <= IDLE;
            end else begin
              fill_y <= fill_y + 7'd1;
            end
          end else begin
            fill_x <= fill_x + 8'd1;
          end
        end

        CLRROW: begin
          // cursor_y already points at the new row when this state is entered.
          wr_en   <= 1'b1;
          wr_x    <= fill_x;
          wr_y    <= cursor_y;
          wr_char <= FILL_CHAR;
          if (fill_x == X_MAX) begin
            fill_x <= '0;
            state  <= IDLE;
          end else begin
            fill_x <= fill_x + 8'd1;
          end
        end

        IDLE: begin
          if (in_valid) begin
            if (is_print) begin
              wr_en   <= 1'b1;
              wr_x    <= cursor_x;
              wr_y    <= cursor_y;
              wr_char <= in_char;
              if (cursor_x == X_MAX) begin
                cursor_x <= '0;
                cursor_y <= next_row;
                fill_x   <= '0;
                state    <= CLRROW;
              end else begin
                cursor_x <= cursor_x + 8'd1;
              end
            end else begin
              case (in_char)
                CH_LF: begin
                  cursor_x <= '0;
                  cursor_y <= next_row;
                  fill_x   <= '0;
                  state    <= CLRROW;
                end
                CH_CR: begin
                  cursor_x <= '0;
                end
                CH_BS: begin
                  // Backspace never leaves the current row.
                  if (cursor_x != '0) begin
                    cursor_x <= cursor_x - 8'd1;
                    wr_en    <= 1'b1;
                    wr_x     <= cursor_x - 8'd1;
                    wr_y     <= cursor_y;
                    wr_char  <= FILL_CHAR;
                  end
                end
                CH_FF: begin
                  cursor_x <= '0;
                  cursor_y <= '0;
                  fill_x   <= '0;
                  fill_y   <= '0;
                  state    <= CLEAR;
                end
`ifdef TEXT_CONSOLE_TAB_EN
                CH_HT: begin
                  if (tab_wrap) begin
                    cursor_x <= '0;
                    cursor_y <= next_row;
                    fill_x   <= '0;
                    state    <= CLRROW;
                  end else begin
                    cursor_x <= tab_next[7:0];
                  end
                end
`endif
                default: ;
              endcase
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
